// File: rtl/tree_uplink_arbiter_pkg.sv
// Shared NoC definitions for the tree routers: flit layout, FSM state
// encoding and the small width helpers used to size ports and counters.
package tree_uplink_arbiter_pkg;

    localparam int NOC_FW = 32;

    // Uplink arbiter states: waiting for a head flit, or locked to one owner.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // Flit as seen on a router port: payload plus packet framing flags.
    typedef struct packed {
        logic              hdr;
        logic              tail;
        logic [NOC_FW-1:0] payload;
    } noc_flit_t;

    // Ceiling log2 with a floor of 1 so a one-entry index still has a bit.
    function automatic int noc_log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        if (r < 1) begin
            r = 1;
        end else begin
            r = r;
        end
        return r;
    endfunction

    // Width of a credit counter that must hold every value 0..depth.
    function automatic int credit_width(input int depth);
        return noc_log2(depth + 1);
    endfunction

endpackage

// File: rtl/tree_uplink_arbiter_if.sv
// Bundle of the requester side and the up-link side of the leaf arbiter.
// slave: the arbiter itself; master: whatever drives requests and credits.
interface tree_uplink_arbiter_if #(
    parameter int K  = 2,
    parameter int Fw = 32,
    parameter int B  = 4
);
    import tree_uplink_arbiter_pkg::*;

    localparam int Cw = credit_width(B);

    logic [K*Fw-1:0] req_flit;
    logic [K-1:0]    req_valid;
    logic [K-1:0]    req_hdr;
    logic [K-1:0]    req_tail;
    logic [K-1:0]    req_ready;
    logic [Fw-1:0]   up_flit_out;
    logic            up_flit_wr;
    logic            up_credit_in;
    logic [K-1:0]    grant_onehot;
    logic [Cw-1:0]   credit_cnt;
    logic            err_credit;

    modport slave (
        input  req_flit, req_valid, req_hdr, req_tail, up_credit_in,
        output req_ready, up_flit_out, up_flit_wr, grant_onehot, credit_cnt, err_credit
    );

    modport master (
        output req_flit, req_valid, req_hdr, req_tail, up_credit_in,
        input  req_ready, up_flit_out, up_flit_wr, grant_onehot, credit_cnt, err_credit
    );

endinterface

// File: rtl/tree_uplink_arbiter_rr.sv
// Combinational round-robin picker: grants the first requester at or after
// the pointer, wrapping modulo K. Shared with the root router's allocator.
module tree_rr_arbiter #(
    parameter int K  = 2,
    parameter int Kw = 1
) (
    input  logic [K-1:0]  i_req,
    input  logic [Kw-1:0] i_ptr,
    output logic [K-1:0]  o_grant
);

    logic [K-1:0]  w_grant;
    logic [Kw-1:0] w_idx;
    logic          w_found;

    // Walk the requesters starting at the pointer and keep the first hit.
    always_comb begin
        w_grant = {K{1'b0}};
        w_idx   = {Kw{1'b0}};
        w_found = 1'b0;
        for (int off = 0; off < K; off++) begin
            w_idx = Kw'((int'(i_ptr) + off) % K);
            if (!w_found && i_req[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end else begin
                w_grant = w_grant;
            end
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/tree_uplink_arbiter.sv
// Leaf-router up-link arbiter: locks the link to one requester from head to
// tail flit, rotates ownership round-robin and never sends without a credit.
module tree_uplink_arbiter
    import tree_uplink_arbiter_pkg::*;
#(
    parameter int K  = 2,
    parameter int Fw = NOC_FW,
    parameter int B  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    tree_uplink_arbiter_if.slave  bus
);

    localparam int Kw = noc_log2(K);
    localparam int Cw = credit_width(B);
    localparam logic [Cw-1:0] CRED_MAX = Cw'(B);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [K-1:0]  r_grant;
    logic [Kw-1:0] r_owner;
    logic [Kw-1:0] r_rr_ptr;
    logic [Fw-1:0] r_up_flit;
    logic          r_up_wr;
    logic [Cw-1:0] r_credit;
    logic          r_err;

    logic [K-1:0]  w_cand;
    logic          w_has_cand;
    logic [K-1:0]  w_arb_grant;
    logic [Kw-1:0] w_win_idx;
    logic [Kw-1:0] w_rr_next;
    logic [Fw-1:0] w_sel_flit;
    logic          w_sel_valid;
    logic          w_sel_tail;
    logic          w_credit_ok;
    logic          w_xfer;
    logic [K-1:0]  w_ready;

    // Only a presented head flit may open a new packet.
    assign w_cand     = bus.req_valid & bus.req_hdr;
    assign w_has_cand = |w_cand;

    tree_rr_arbiter #(
        .K  (K),
        .Kw (Kw)
    ) u_rr (
        .i_req   (w_cand),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant)
    );

    // Convert the one-hot winner into an index for the owner register.
    always_comb begin
        w_win_idx = {Kw{1'b0}};
        for (int k = 0; k < K; k++) begin
            if (w_arb_grant[k]) begin
                w_win_idx = Kw'(k);
            end else begin
                w_win_idx = w_win_idx;
            end
        end
    end

    // Steer the current owner's flit and framing onto the up-link path.
    always_comb begin
        w_sel_flit  = bus.req_flit[int'(r_owner) * Fw +: Fw];
        w_sel_valid = bus.req_valid[r_owner];
        w_sel_tail  = bus.req_tail[r_owner];
    end

    assign w_credit_ok = (r_credit != {Cw{1'b0}});
    assign w_xfer      = (r_state == ST_LOCK) & w_sel_valid & w_credit_ok;
    assign w_ready     = w_xfer ? r_grant : {K{1'b0}};
    assign w_rr_next   = (r_owner == Kw'(K - 1)) ? {Kw{1'b0}} : (r_owner + Kw'(1'b1));

    // Next state: lock on any head, release after the owner's tail moves.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_has_cand) begin
                    w_state_nxt = ST_LOCK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (w_xfer && w_sel_tail) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_LOCK;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ownership: capture the winner when locking, rotate the pointer on tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant  <= {K{1'b0}};
            r_owner  <= {Kw{1'b0}};
            r_rr_ptr <= {Kw{1'b0}};
        end else if ((r_state == ST_IDLE) && w_has_cand) begin
            r_grant <= w_arb_grant;
            r_owner <= w_win_idx;
        end else if (w_xfer && w_sel_tail) begin
            r_grant  <= {K{1'b0}};
            r_rr_ptr <= w_rr_next;
        end else begin
            r_grant  <= r_grant;
            r_owner  <= r_owner;
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // Up-link output register: one-cycle delay from accept to write strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_up_flit <= {Fw{1'b0}};
            r_up_wr   <= 1'b0;
        end else if (w_xfer) begin
            r_up_flit <= w_sel_flit;
            r_up_wr   <= 1'b1;
        end else begin
            r_up_flit <= r_up_flit;
            r_up_wr   <= 1'b0;
        end
    end

    // Credit counter: a send and a return in the same cycle cancel out; a
    // return into a full counter is dropped and flagged permanently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credit <= CRED_MAX;
            r_err    <= 1'b0;
        end else begin
            case ({w_xfer, bus.up_credit_in})
                2'b10: begin
                    r_credit <= r_credit - Cw'(1'b1);
                    r_err    <= r_err;
                end
                2'b01: begin
                    if (r_credit == CRED_MAX) begin
                        r_credit <= r_credit;
                        r_err    <= 1'b1;
                    end else begin
                        r_credit <= r_credit + Cw'(1'b1);
                        r_err    <= r_err;
                    end
                end
                default: begin
                    r_credit <= r_credit;
                    r_err    <= r_err;
                end
            endcase
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.up_flit_out  = r_up_flit;
    assign bus.up_flit_wr   = r_up_wr;
    assign bus.grant_onehot = r_grant;
    assign bus.credit_cnt   = r_credit;
    assign bus.err_credit   = r_err;

endmodule
